hazard_forward_unit: RTL

HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

---
 rtl/hazard_forward_unit_pkg.sv | 16 +
 rtl/hazard_forward_unit_fwd_sel_unit.sv | 30 +++
 rtl/hazard_forward_unit.sv | 139 +++++++++++++
 3 files changed

// File: rtl/hazard_forward_unit_pkg.sv
// Shared encodings for the hazard/forwarding unit and the EX operand muxes.
package hazard_forward_unit_pkg;

  localparam int unsigned FWD_W = 2;
  localparam int unsigned REM_W = 4;

  localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
  localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;
  localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    IDLE     = 1'b0,
    LU_STALL = 1'b1
  } fsm_state_e;

endpackage

// File: rtl/hazard_forward_unit_fwd_sel_unit.sv
// Single-source forwarding select: EX/MEM beats MEM/WB, and r0 is never forwarded.
module fwd_sel_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_i,
  input  logic [REG_AW-1:0] ex_mem_rd_i,
  input  logic              ex_mem_reg_write_i,
  input  logic [REG_AW-1:0] mem_wb_rd_i,
  input  logic              mem_wb_reg_write_i,
  output logic [FWD_W-1:0]  sel_c_o
);

  logic mem_hit_c;
  logic wb_hit_c;

  assign mem_hit_c = ex_mem_reg_write_i && (ex_mem_rd_i != '0) && (ex_mem_rd_i == rs_i);
  assign wb_hit_c  = mem_wb_reg_write_i && (mem_wb_rd_i != '0) && (mem_wb_rd_i == rs_i);

  always_comb begin
    sel_c_o = FWD_RF;
    if (mem_hit_c) begin
      sel_c_o = FWD_MEM;
    end else if (wb_hit_c) begin
      sel_c_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Operand forwarding selects, load-use stall/bubble sequencing and a stall counter.
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned LOAD_STALL = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_SRC*REG_AW-1:0]   id_rs,
  input  logic [NUM_SRC-1:0]          id_rs_vld,
  input  logic [NUM_SRC*REG_AW-1:0]   ex_rs,
  input  logic [REG_AW-1:0]           id_ex_rd,
  input  logic                        id_ex_mem_read,
  input  logic [REG_AW-1:0]           ex_mem_rd,
  input  logic                        ex_mem_reg_write,
  input  logic [REG_AW-1:0]           mem_wb_rd,
  input  logic                        mem_wb_reg_write,
  input  logic                        hold,
  input  logic                        flush,
  input  logic                        cnt_clr,
  output logic [FWD_W*NUM_SRC-1:0]    fwd_sel,
  output logic                        stall,
  output logic                        bubble,
  output logic [CNT_W-1:0]            stall_cnt
);

  fsm_state_e       state_q, state_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit_c;
  logic             src_match_c;
  logic             stall_raw_c, bubble_raw_c;
  logic             stall_c, bubble_c;

  // Forwarding stays purely combinational so hold/flush never mask it.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_sel_unit #(
      .REG_AW(REG_AW)
    ) u_fwd_sel (
      .rs_i               (ex_rs[i*REG_AW +: REG_AW]),
      .ex_mem_rd_i        (ex_mem_rd),
      .ex_mem_reg_write_i (ex_mem_reg_write),
      .mem_wb_rd_i        (mem_wb_rd),
      .mem_wb_reg_write_i (mem_wb_reg_write),
      .sel_c_o            (fwd_sel[i*FWD_W +: FWD_W])
    );
  end

  always_comb begin
    src_match_c = 1'b0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (id_rs_vld[i] && (id_rs[i*REG_AW +: REG_AW] == id_ex_rd)) begin
        src_match_c = 1'b1;
      end
    end
    hit_c = id_ex_mem_read && (id_ex_rd != '0) && src_match_c;
  end

  // Priority: flush, then hold, then the load-use sequence.
  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    stall_raw_c  = 1'b0;
    bubble_raw_c = 1'b0;
    if (flush) begin
      bubble_raw_c = 1'b1;
      state_d      = IDLE;
      rem_d        = '0;
    end else if (hold) begin
      stall_raw_c  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (hit_c) begin
            stall_raw_c  = 1'b1;
            bubble_raw_c = 1'b1;
            if (LOAD_STALL > 1) begin
              state_d = LU_STALL;
              rem_d   = REM_W'(LOAD_STALL - 1);
            end
          end
        end
        LU_STALL: begin
          stall_raw_c  = 1'b1;
          bubble_raw_c = 1'b1;
          if (rem_q <= REM_W'(1)) begin
            state_d = IDLE;
            rem_d   = '0;
          end else begin
            rem_d   = rem_q - REM_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          rem_d   = '0;
        end
      endcase
    end
  end

  // Outputs are held low for the whole reset window, not just at the next edge.
  assign stall_c  = rst_n & stall_raw_c;
  assign bubble_c = rst_n & bubble_raw_c;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (stall_c && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall     = stall_c;
  assign bubble    = bubble_c;
  assign stall_cnt = cnt_q;

endmodule
